// File: rtl/timer_pkg.sv
// Shared definitions for the round timer and its display.
// Holds the controller state encoding, the maximum round length, the width
// and type of the seconds count (also consumed by timer_display), and a
// helper that clamps a signed intermediate count into the legal range.
package timer_pkg;

    localparam int MAX_SECONDS = 30;
    localparam int TIME_W      = 6;

    typedef logic [TIME_W-1:0] time_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

    // Clamp a signed 8-bit seconds value into [0, MAX_SECONDS].
    function automatic time_t sat_seconds(input logic signed [7:0] v);
        if (v < 8'sd0) begin
            return '0;
        end else if (v > 8'(MAX_SECONDS)) begin
            return time_t'(MAX_SECONDS);
        end else begin
            return v[TIME_W-1:0];
        end
    endfunction

endpackage

// File: rtl/round_timer_ctrl_if.sv
// Game-logic <-> round timer signal bundle.
// master : game logic, drives the one-cycle command pulses and observes status.
// slave  : round_timer_ctrl, consumes commands and drives the status outputs.
//   start, pause, bonus, penalty : one-cycle command pulses
//   time_remaining               : current seconds (0..MAX_SECONDS)
//   running, timeout, low_time   : status flags (timeout is a one-cycle pulse)
//   display_clk                  : digit-multiplex square wave for the display
interface round_timer_ctrl_if;
    import timer_pkg::*;

    logic  start;
    logic  pause;
    logic  bonus;
    logic  penalty;
    time_t time_remaining;
    logic  running;
    logic  timeout;
    logic  low_time;
    logic  display_clk;

    modport master (
        output start, pause, bonus, penalty,
        input  time_remaining, running, timeout, low_time, display_clk
    );

    modport slave (
        input  start, pause, bonus, penalty,
        output time_remaining, running, timeout, low_time, display_clk
    );
endinterface

// File: rtl/pulse_divider.sv
// Enable-gated modulo-DIV counter producing a one-cycle tick.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   en     : advance the counter this cycle (counter holds when low)
//   clr    : force the counter to 0; overrides en
//   tick   : high on the cycle the counter sits at DIV-1 while enabled;
//            the counter wraps to 0 on that same edge
module pulse_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = en && !clr && (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/round_timer_ctrl.sv
// Round-timer controller: loads the round length on start, counts down once
// per TICK_DIV cycles while running, applies bonus/penalty adjustments with
// saturation, flags expiry, and generates the display refresh clock.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : round_timer_ctrl_if.slave (commands in, status/display_clk out)
// All outputs come straight from registers.
module round_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV        = 100_000_000,
    parameter int REFRESH_DIV     = 100_000,
    parameter int ROUND_SECONDS   = 30,
    parameter int BONUS_SECONDS   = 3,
    parameter int PENALTY_SECONDS = 5,
    parameter int LOW_SECONDS     = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    round_timer_ctrl_if.slave   bus
);
    timer_state_t      state_reg, state_next;
    time_t             time_reg, time_next;
    logic              running_reg, running_next;
    logic              timeout_reg, timeout_next;
    logic              low_reg, low_next;
    logic              disp_reg;
    logic signed [7:0] sum_next;

    logic sec_tick;
    logic refresh_tick;
    logic presc_en;
    logic presc_clr;

    // Prescaler advances only in RUN, holds in PAUSED so a pause keeps the
    // partial second, and is zeroed whenever a round is not in progress.
    assign presc_en  = (state_reg == ST_RUN);
    assign presc_clr = bus.start || (state_reg == ST_IDLE) || (state_reg == ST_EXPIRED);

    pulse_divider #(.DIV(TICK_DIV)) u_sec_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .clr   (presc_clr),
        .tick  (sec_tick)
    );

    pulse_divider #(.DIV(REFRESH_DIV)) u_refresh (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .tick  (refresh_tick)
    );

    always_comb begin
        state_next   = state_reg;
        time_next    = time_reg;
        timeout_next = 1'b0;

        sum_next = signed'({2'b00, time_reg});
        if (sec_tick) begin
            sum_next = sum_next - 8'sd1;
        end
        if (bus.bonus) begin
            sum_next = sum_next + 8'(BONUS_SECONDS);
        end
        if (bus.penalty) begin
            sum_next = sum_next - 8'(PENALTY_SECONDS);
        end

        if (bus.start) begin
            state_next = ST_RUN;
            time_next  = time_t'(ROUND_SECONDS);
        end else begin
            case (state_reg)
                ST_RUN, ST_PAUSED: begin
                    time_next = sat_seconds(sum_next);
                    // Reaching zero ends the round even if pause arrives
                    // on the same cycle.
                    if (time_next == '0) begin
                        state_next   = ST_EXPIRED;
                        timeout_next = 1'b1;
                    end else if (bus.pause) begin
                        state_next = (state_reg == ST_RUN) ? ST_PAUSED : ST_RUN;
                    end
                end
                default: begin
                    // IDLE and EXPIRED ignore pause, bonus and penalty.
                end
            endcase
        end

        running_next = (state_next == ST_RUN);
        low_next     = ((state_next == ST_RUN) || (state_next == ST_PAUSED)) &&
                       (time_next <= TIME_W'(LOW_SECONDS));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            time_reg    <= '0;
            running_reg <= 1'b0;
            timeout_reg <= 1'b0;
            low_reg     <= 1'b0;
            disp_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            time_reg    <= time_next;
            running_reg <= running_next;
            timeout_reg <= timeout_next;
            low_reg     <= low_next;
            disp_reg    <= disp_reg ^ refresh_tick;
        end
    end

    assign bus.time_remaining = time_reg;
    assign bus.running        = running_reg;
    assign bus.timeout        = timeout_reg;
    assign bus.low_time       = low_reg;
    assign bus.display_clk    = disp_reg;
endmodule

// File: doc/round_timer_ctrl.md
# round_timer_ctrl

Round-timer controller for the binary game. It owns the countdown that drives the 7-segment timer display: it loads the round length, decrements once per second, and applies bonus and penalty adjustments from game logic. It also generates the display refresh clock and flags expiry to the game FSM. It sits between the game logic and `timer_display`, feeding that block's `time_remaining` and `display_clk` inputs.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per countdown second.
- `REFRESH_DIV`, 100_000: clk cycles per half-period of `display_clk`.
- `ROUND_SECONDS`, 30: value loaded on start (≤ `MAX_SECONDS`).
- `BONUS_SECONDS`, 3: seconds added per `bonus` pulse.
- `PENALTY_SECONDS`, 5: seconds removed per `penalty` pulse.
- `LOW_SECONDS`, 5: threshold for `low_time`.

Ports:
- `clk` in 1: system clock. The block has one clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse; loads `ROUND_SECONDS` and enters RUN.
- `pause` in 1: one-cycle pulse; toggles RUN↔PAUSED.
- `bonus` in 1: one-cycle pulse; adds `BONUS_SECONDS`.
- `penalty` in 1: one-cycle pulse; subtracts `PENALTY_SECONDS`.
- `time_remaining` out 6: current seconds, range 0..30.
- `running` out 1: high in RUN.
- `timeout` out 1: one-cycle expiry pulse.
- `low_time` out 1: high when in RUN or PAUSED and `time_remaining` ≤ `LOW_SECONDS`.
- `display_clk` out 1: square wave for display digit multiplexing.

## Operation
- States are IDLE, RUN, PAUSED and EXPIRED. Reset enters IDLE.
- Transitions:
  - `start` in any state → RUN, with `time_remaining` = `ROUND_SECONDS` and the prescaler cleared.
  - `pause` in RUN → PAUSED.
  - `pause` in PAUSED → RUN.
  - `pause` in IDLE or EXPIRED is ignored.
  - Count reaching 0 in RUN or PAUSED → EXPIRED.
  - EXPIRED holds until `start`.
- Prescaler:
  - Counts 0..`TICK_DIV`-1, only in RUN.
  - It holds its value in PAUSED, so a pause does not lose the partial second.
  - It is cleared in IDLE, in EXPIRED and on `start`.
  - An internal `sec_tick` fires on the cycle the prescaler equals `TICK_DIV`-1; the prescaler wraps to 0 on that cycle.
- Count update (RUN or PAUSED, no `start`):
  - next = time − `sec_tick` + `bonus`·`BONUS_SECONDS` − `penalty`·`PENALTY_SECONDS`.
  - Evaluate in signed 8-bit, then saturate to [0, `MAX_SECONDS`].
  - `bonus` and `penalty` in the same cycle both apply.
- Ignored inputs: `bonus` and `penalty` are ignored in IDLE and EXPIRED.
- Priority: `start` > `pause` > count update. A count update is still applied on a `pause` cycle.
- Expiry: when next = 0, the state goes to EXPIRED and `timeout` = 1 for one cycle. `timeout` is never reasserted until after a new `start`.
- `display_clk`:
  - Free-running divider; it toggles every `REFRESH_DIV` cycles in all states.
  - It is independent of the FSM.

## Timing
- Reset values: state IDLE; `time_remaining` 0, `running` 0, `timeout` 0, `low_time` 0, `display_clk` 0; both divider counters 0.
- All outputs are registered.
- `start` at edge N: `time_remaining` = `ROUND_SECONDS` and `running` = 1 after edge N. The first decrement lands `TICK_DIV` cycles later.
- Tick, bonus and penalty effects are visible one cycle after the triggering edge.
- `timeout` rises on the same edge that `time_remaining` becomes 0 and falls on the next edge.
- `rst_n` low mid-round forces reset values on the next edge and overrides every other input.
- `start` on the same cycle as expiry restarts the round; `timeout` is not asserted.

## Structure
- Package `timer_pkg` holds:
  - the state enum;
  - `MAX_SECONDS` = 30;
  - `TIME_W` = 6;
  - the shared type for `time_remaining`, also used by `timer_display`.
- Sub-module `pulse_divider` (parameter `DIV`, inputs `clk`/`rst_n`/`en`/`clr`, output one-cycle `tick`) is instantiated twice:
  - as the seconds prescaler;
  - as the refresh source, with `display_clk` toggled on each refresh `tick`.

## Test plan
Bench parameters: `TICK_DIV`=4, `REFRESH_DIV`=2, `ROUND_SECONDS`=30, `BONUS_SECONDS`=3, `PENALTY_SECONDS`=5, `LOW_SECONDS`=5.

1. Reset, then `start`. Required: `time_remaining` 30, `running` 1. After 120 cycles: 0, one-cycle `timeout`, state EXPIRED. `low_time` rises when the count reaches 5.
2. `start`, wait 6 cycles, `pause` for 20 cycles, then `pause` again. Required: count frozen at 29 while paused; next decrement after the 2 remaining prescaler cycles.
3. At count 29, `bonus` twice. Required: count 30, not 35 (saturates). At count 4, `penalty`. Required: count 0, `timeout` pulse, EXPIRED.
4. `bonus`, `penalty` and `sec_tick` all in the same cycle at count 10. Required: count 7.
5. `rst_n` low at count 17 in RUN. Required: all outputs 0 on the next edge. `bonus`/`pause` in IDLE: no change.
6. `display_clk` toggles every 2 cycles from reset, in all states. `start` asserted on the expiry cycle: count 30, no `timeout`.
